// File: rtl/sram_arb_pkg.sv
// Shared widths and one-hot state encoding for the SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;

  typedef enum logic [6:0] {
    IDLE     = 7'b0000001,
    WR_SETUP = 7'b0000010,
    WR_PULSE = 7'b0000100,
    WR_HOLD  = 7'b0001000,
    RD_SETUP = 7'b0010000,
    RD_WAIT  = 7'b0100000,
    RD_DONE  = 7'b1000000
  } state_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way write/read pick: fixed write priority or round-robin on ties.
module sram_rr_arb #(
  parameter int WR_PRIO = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_wr_req,
  input  logic i_rd_req,
  output logic o_gnt_wr,
  output logic o_gnt_rd
);

  logic r_last_rd;

  always_comb begin
    o_gnt_wr = 1'b0;
    o_gnt_rd = 1'b0;
    if (i_en) begin
      // On a tie, write wins under priority mode or when read was served last.
      if (i_wr_req && (!i_rd_req || (WR_PRIO != 0) || r_last_rd))
        o_gnt_wr = 1'b1;
      else if (i_rd_req)
        o_gnt_rd = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_last_rd <= 1'b1;
    else if (o_gnt_wr)
      r_last_rd <= 1'b0;
    else if (o_gnt_rd)
      r_last_rd <= 1'b1;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates a camera write port and a read port onto one async SRAM,
// generating CE/OE/WE timing and owning the bidirectional data bus.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WE_CYCLES = 2,
  parameter int RD_CYCLES = 2,
  parameter int WR_PRIO   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] DATA,
  output logic              CE,
  output logic              OE,
  output logic              WE
);

  localparam logic [2:0] WE_LAST = 3'(WE_CYCLES - 1);
  localparam logic [2:0] RD_LAST = 3'(RD_CYCLES - 1);

  state_t              r_state, w_next;
  logic [2:0]          r_cnt, w_cnt_next;
  logic                w_gnt_wr, w_gnt_rd;
  logic                r_ce, r_oe, r_we, r_drive, r_busy;
  logic                r_wr_ack, r_rd_ack, r_rd_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_dout, r_rd_data;

  sram_rr_arb #(
    .WR_PRIO (WR_PRIO)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_state == IDLE),
    .i_wr_req (wr_req),
    .i_rd_req (rd_req),
    .o_gnt_wr (w_gnt_wr),
    .o_gnt_rd (w_gnt_rd)
  );

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_next = 3'd0;
        if (w_gnt_wr)      w_next = WR_SETUP;
        else if (w_gnt_rd) w_next = RD_SETUP;
      end
      WR_SETUP: begin
        w_next     = WR_PULSE;
        w_cnt_next = 3'd0;
      end
      WR_PULSE: begin
        if (r_cnt == WE_LAST) begin
          w_next     = WR_HOLD;
          w_cnt_next = 3'd0;
        end else begin
          w_cnt_next = r_cnt + 3'd1;
        end
      end
      WR_HOLD:  w_next = IDLE;
      RD_SETUP: begin
        w_next     = RD_WAIT;
        w_cnt_next = 3'd0;
      end
      RD_WAIT: begin
        if (r_cnt == RD_LAST) begin
          w_next     = RD_DONE;
          w_cnt_next = 3'd0;
        end else begin
          w_cnt_next = r_cnt + 3'd1;
        end
      end
      RD_DONE:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Pin and status registers are loaded from the next state so every output
  // lines up with the state it belongs to without a combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_ce       <= 1'b1;
      r_oe       <= 1'b1;
      r_we       <= 1'b1;
      r_drive    <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_ack   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_addr     <= '0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_ce       <= (w_next == IDLE);
      r_oe       <= !(w_next inside {RD_SETUP, RD_WAIT});
      r_we       <= (w_next != WR_PULSE);
      r_drive    <= (w_next inside {WR_SETUP, WR_PULSE, WR_HOLD});
      r_busy     <= (w_next != IDLE);
      r_wr_ack   <= w_gnt_wr;
      r_rd_ack   <= w_gnt_rd;
      r_rd_valid <= (w_next == RD_DONE);
      if (w_gnt_wr)
        r_addr <= wr_addr;
      else if (w_gnt_rd)
        r_addr <= rd_addr;
      if (r_state == RD_WAIT && w_next == RD_DONE)
        r_rd_data <= DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt_wr)
      r_dout <= wr_data;
  end

  assign DATA     = r_drive ? r_dout : {DATA_W{1'bz}};
  assign ADDR     = r_addr;
  assign CE       = r_ce;
  assign OE       = r_oe;
  assign WE       = r_we;
  assign busy     = r_busy;
  assign wr_ack   = r_wr_ack;
  assign rd_ack   = r_rd_ack;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural async SRAM on the bus.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int WE_C = 2;
  localparam int RD_C = 2;

  typedef struct {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              wr_req = 1'b0, rd_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0, rd_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ack, rd_ack, rd_valid, busy, CE, OE, WE;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ADDR;
  wire  [DATA_W-1:0] DATA;

  logic              p_wr_req = 1'b0, p_rd_req = 1'b0;
  logic              p_wr_ack, p_rd_ack, p_rd_valid, p_busy, p_CE, p_OE, p_WE;
  logic [DATA_W-1:0] p_rd_data;
  logic [ADDR_W-1:0] p_ADDR;
  wire  [DATA_W-1:0] p_DATA;

  sram_arbiter #(.WE_CYCLES(WE_C), .RD_CYCLES(RD_C), .WR_PRIO(0)) u_dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .ADDR(ADDR), .DATA(DATA), .CE(CE), .OE(OE), .WE(WE)
  );

  sram_arbiter #(.WE_CYCLES(WE_C), .RD_CYCLES(RD_C), .WR_PRIO(1)) u_dut_p (
    .clk(clk), .rst(rst),
    .wr_req(p_wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(p_wr_ack),
    .rd_req(p_rd_req), .rd_addr(rd_addr), .rd_ack(p_rd_ack),
    .rd_data(p_rd_data), .rd_valid(p_rd_valid), .busy(p_busy),
    .ADDR(p_ADDR), .DATA(p_DATA), .CE(p_CE), .OE(p_OE), .WE(p_WE)
  );

  // Async SRAM model: drives the bus while selected and output-enabled.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              sram_oe;
  logic [DATA_W-1:0] sram_q;
  assign sram_oe = !CE && !OE;
  assign sram_q  = mem[ADDR];
  assign DATA    = sram_oe ? sram_q : {DATA_W{1'bz}};
  always @(posedge clk) if (!CE && !WE) mem[ADDR] <= DATA;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] exp_rd[$];
  bit                exp_p[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  exp_t              m_e;
  bit                m_pk;
  int                we_run, oe_run, busy_run, last_ack, rd_ack_cyc;
  bit                have_last, in_write;
  logic [DATA_W-1:0] cur_wdata;

  always @(negedge clk) begin
    if (rst) begin
      we_run = 0; oe_run = 0; busy_run = 0; have_last = 0; in_write = 0;
    end else begin
      chk("oe_we_overlap", 32'(!OE && !WE), 0);
      if (sram_oe) chk("bus_read_clean", 32'(DATA), 32'(sram_q));
      if (wr_ack || rd_ack) begin
        if (exp_q.size() == 0) chk("unexpected_ack", 32'({wr_ack, rd_ack}), 0);
        else begin
          m_e = exp_q.pop_front();
          chk("ack_kind", 32'({wr_ack, rd_ack}), m_e.is_wr ? 2 : 1);
          chk("ack_addr", 32'(ADDR), 32'(m_e.addr));
          if (m_e.is_wr) begin
            in_write  = 1;
            cur_wdata = m_e.data;
          end else rd_ack_cyc = cyc;
        end
        if (have_last) chk("ack_gap_min", 32'(cyc - last_ack >= 5), 1);
        last_ack  = cyc;
        have_last = 1;
      end
      if (in_write && busy) chk("wr_data_bus", 32'(DATA), 32'(cur_wdata));
      if (!busy) in_write = 0;
      if (!WE) we_run++;
      else if (we_run != 0) begin chk("we_low_len", we_run, WE_C); we_run = 0; end
      if (!OE) oe_run++;
      else if (oe_run != 0) begin chk("oe_low_len", oe_run, RD_C + 1); oe_run = 0; end
      if (busy) busy_run++;
      else if (busy_run != 0) begin chk("busy_len", busy_run, 4); busy_run = 0; end
      if (rd_valid) begin
        if (exp_rd.size() == 0) chk("unexpected_rd_valid", 1, 0);
        else chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
        chk("rd_valid_latency", cyc - rd_ack_cyc, RD_C + 1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (p_wr_ack || p_rd_ack)) begin
      if (exp_p.size() == 0) chk("prio_unexpected_ack", 32'({p_wr_ack, p_rd_ack}), 0);
      else begin
        m_pk = exp_p.pop_front();
        chk("prio_kind", 32'({p_wr_ack, p_rd_ack}), m_pk ? 2 : 1);
      end
    end
  end

  task automatic wait_ack(input bit is_wr, input bit prio);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = prio ? (is_wr ? p_wr_ack : p_rd_ack) : (is_wr ? wr_ack : rd_ack);
    end
    if (!ok) chk("ack_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = !busy;
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back('{1'b1, a, d});
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    wait_ack(1'b1, 1'b0);
    wr_req = 1'b0; wr_addr = ~a; wr_data = ~d;
    wait_idle();
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back('{1'b0, a, 8'h00});
    exp_rd.push_back(d);
    rd_addr = a; rd_req = 1'b1;
    wait_ack(1'b0, 1'b0);
    rd_req = 1'b0; rd_addr = ~a;
    wait_idle();
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_CE"}, 32'(CE), 1);
    chk({tag, "_OE"}, 32'(OE), 1);
    chk({tag, "_WE"}, 32'(WE), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ADDR"}, 32'(ADDR), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_acks"}, 32'({wr_ack, rd_ack, rd_valid}), 0);
  endtask

  int n;
  int t[4];

  initial begin
    repeat (2) @(negedge clk);
    chk_idle_pins("reset");
    rst = 1'b0;
    @(negedge clk);

    do_write(18'h00001, 8'hAA);
    do_read(18'h00001, 8'hAA);
    do_write(18'h00005, 8'h3C);
    do_write(18'h3FFFF, 8'h55);
    do_read(18'h3FFFF, 8'h55);
    do_read(18'h00005, 8'h3C);

    // Write request raised and withdrawn while a read is in flight.
    exp_q.push_back('{1'b0, 18'h00001, 8'h00});
    exp_rd.push_back(8'hAA);
    rd_addr = 18'h00001; rd_req = 1'b1;
    wait_ack(1'b0, 1'b0);
    rd_req = 1'b0; wr_addr = 18'h00007; wr_data = 8'hEE; wr_req = 1'b1;
    repeat (2) @(negedge clk);
    wr_req = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // Reset in the middle of the WE pulse.
    exp_q.push_back('{1'b1, 18'h00020, 8'h99});
    wr_addr = 18'h00020; wr_data = 8'h99; wr_req = 1'b1;
    wait_ack(1'b1, 1'b0);
    wr_req = 1'b0;
    for (int i = 0; i < 10 && WE; i++) @(negedge clk);
    chk("we_pulse_reached", 32'(WE), 0);
    #2 rst = 1'b1;
    #1 chk_idle_pins("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_reset_quiet", 32'(busy), 0);

    // Both requests held: round-robin starting with write after reset.
    wr_addr = 18'h00010; wr_data = 8'h77; rd_addr = 18'h00005;
    exp_q.push_back('{1'b1, 18'h00010, 8'h77});
    exp_q.push_back('{1'b0, 18'h00005, 8'h00});
    exp_q.push_back('{1'b1, 18'h00010, 8'h77});
    exp_q.push_back('{1'b0, 18'h00005, 8'h00});
    exp_rd.push_back(8'h3C);
    exp_rd.push_back(8'h3C);
    wr_req = 1'b1; rd_req = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (wr_ack || rd_ack) begin t[n] = cyc; n++; end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("tie_grant_count", n, 4);
    for (int k = 1; k < 4; k++) chk("b2b_gap", t[k] - t[k-1], 5);
    wait_idle();

    // Write-priority instance: writes win every tie while write is held.
    for (int k = 0; k < 4; k++) exp_p.push_back(1'b1);
    exp_p.push_back(1'b0);
    wr_addr = 18'h00030; wr_data = 8'h11; rd_addr = 18'h00031;
    p_wr_req = 1'b1; p_rd_req = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (p_wr_ack || p_rd_ack) n++;
    end
    p_wr_req = 1'b0;
    chk("prio_grant_count", n, 4);
    wait_ack(1'b0, 1'b1);
    p_rd_req = 1'b0;
    repeat (10) @(negedge clk);

    chk("scoreboard_drained", exp_q.size() + exp_rd.size() + exp_p.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: WE_CYCLES, 2, WE low-pulse length in clk cycles (1..7).
REQ-002 Parameter: RD_CYCLES, 2, OE-low cycles before data capture (1..7).
REQ-003 Parameter: WR_PRIO, 0, 1 = write port always wins ties; 0 = round-robin.
REQ-004 Ports: clk input 1 system clock; rst input 1 reset.
REQ-005 Clock/reset: one clock, clk; reset rst is asynchronous and active-high.
REQ-006 Ports: wr_req input 1 camera write request, level, held until wr_ack.
REQ-007 Ports: wr_addr input 18 write address; wr_data input 8 write data; wr_ack output 1 one-cycle grant pulse.
REQ-008 Ports: rd_req input 1 read request, level, held until rd_ack; rd_addr input 18 read address; rd_ack output 1 one-cycle grant pulse.
REQ-009 Ports: rd_data output 8 captured read byte; rd_valid output 1 one-cycle pulse, rd_data valid.
REQ-010 Ports: busy output 1 high whenever state is not IDLE.
REQ-011 Ports: ADDR output 18 SRAM address; DATA inout 8 SRAM data; CE, OE, WE output 1 each, active-low.

Function
REQ-012 States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_WAIT, RD_DONE; requests sampled only in IDLE.
REQ-013 IDLE: CE=OE=WE=1; DATA released (high-Z); ADDR holds last value.
REQ-014 Grant: in IDLE with a request pending, latch address (and data), go to WR_SETUP or RD_SETUP; the matching ack is high for exactly the first cycle of that setup state.
REQ-015 Tie (both requests): WR_PRIO=1 grants write; WR_PRIO=0 grants the port not granted last; last-grant flag resets to "read", so the first tie goes to write.
REQ-016 Write: WR_SETUP 1 cycle (CE=0, WE=1, ADDR and DATA driven); WR_PULSE WE_CYCLES cycles (WE=0); WR_HOLD 1 cycle (WE=1, DATA still driven); then IDLE; total WE_CYCLES+2 cycles.
REQ-017 DATA is driven only in WR_SETUP, WR_PULSE and WR_HOLD; never in read or IDLE states.
REQ-018 Read: RD_SETUP 1 cycle (CE=0, OE=0, ADDR driven); RD_WAIT RD_CYCLES cycles (OE=0); DATA captured into rd_data on the last RD_WAIT edge; RD_DONE 1 cycle (OE=1, rd_valid=1); then IDLE; total RD_CYCLES+2 cycles.
REQ-019 rd_data holds the last captured byte until the next capture.
REQ-020 Back-to-back: a request pending on return to IDLE is granted after one IDLE cycle; minimum one IDLE cycle between accesses.
REQ-021 A request dropped before its ack is not served; it causes no bus activity.
REQ-022 wr_addr, rd_addr and wr_data may change once ack is seen; the latched copies are used.
REQ-023 Full 18-bit address range 0..18'h3FFFF is valid; no wrap or increment is performed internally.
REQ-024 All outputs are registered; no combinational path from req to SRAM pins.

Reset
REQ-025 rst=1 forces immediately, including mid-access: state IDLE, CE=OE=WE=1, DATA high-Z, ADDR=0, wr_ack=rd_ack=rd_valid=0, rd_data=0, busy=0, last-grant=read.
REQ-026 An access interrupted by reset is dropped; it is not resumed and gets no ack or valid afterwards.

Structure
REQ-027 Package sram_arb_pkg holds ADDR_W=18, DATA_W=8, and the state encoding (one-hot, 7 bits).
REQ-028 One sub-module, sram_rr_arb: 2-way round-robin/priority pick with last-grant register; the FSM, SRAM timing and tri-state stay in sram_arbiter.

Verification
REQ-029 Write 8'hAA to 18'h00001 with defaults: wr_ack 1 cycle, WE low exactly 2 cycles, DATA=AA from WR_SETUP through WR_HOLD, busy 4 cycles.
REQ-030 Read 18'h00001, SRAM model returns 8'hAA: OE low 3 cycles, rd_valid pulse 4 cycles after grant, rd_data=AA.
REQ-031 wr_req and rd_req held together for 4 grants with WR_PRIO=0: order W,R,W,R. With WR_PRIO=1: W,W,W,W while wr_req is held.
REQ-032 Assert rst during WR_PULSE: WE, CE and OE return to 1 and DATA goes high-Z in the same cycle; no further acks.
REQ-033 Write then read at 18'h3FFFF with 8'h55: ADDR=3FFFF on both accesses, rd_data=55; DATA is never driven by both sides at once (checked by a bus monitor).
